// File: rtl/seven_segment_scanner_if.sv
// Bus between the digit scanner and its controller: load/enable controls in, scan drive out.
// Clock and reset are plain ports on the scanner.
interface seven_segment_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                    enable;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic                    lz_en;
    logic [3:0]              bin;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   dig_sel_n;
    logic                    frame_start;
    logic                    pending;

    modport master (
        output enable, value, load, lz_en,
        input  bin, blank, dig_sel_n, frame_start, pending
    );

    modport slave (
        input  enable, value, load, lz_en,
        output bin, blank, dig_sel_n, frame_start, pending
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed digit scanner with double-buffered value, leading-zero blanking and
// an all-off guard interval at the start of every digit slot.
module seven_segment_scanner #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 1000,
    parameter int unsigned GUARD      = 50
) (
    input logic                     clk,
    input logic                     rst_n,
    seven_segment_scanner_if.slave  bus_io
);
    localparam int unsigned CntW = $clog2(PRESCALE);
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned ValW = 4 * NUM_DIGITS;
    localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

    typedef enum logic {StIdle, StScan} state_e;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [IdxW-1:0]       idx_q;
    logic [ValW-1:0]       disp_q;
    logic [ValW-1:0]       pend_q;
    logic                  pend_flag_q;
    logic                  lz_en_q;

    logic                  frame_xfer;
    logic                  in_guard;
    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz;

    logic [3:0]            bin;
    logic                  blank;
    logic [NUM_DIGITS-1:0] dig_sel_n;
    logic                  frame_start;

    // Frame boundary: entering SCAN from IDLE, or wrapping past the last digit slot.
    always_comb begin
        frame_xfer = bus_io.enable &&
                     ((state_q == StIdle) || ((cnt_q == CntLast) && (idx_q == IdxLast)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            lz_en_q     <= 1'b0;
        end else begin
            lz_en_q <= bus_io.lz_en;
            case (state_q)
                StIdle: begin
                    if (bus_io.enable) begin
                        state_q <= StScan;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                StScan: begin
                    if (!bus_io.enable) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        cnt_q <= '0;
                        idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (frame_xfer && pend_flag_q) begin
                disp_q      <= pend_q;
                pend_flag_q <= 1'b0;
            end
            // A load on the transfer cycle wins the flag: the new value waits a frame.
            if (bus_io.load) begin
                pend_q      <= bus_io.value;
                pend_flag_q <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            nib[i] = disp_q[4*i +: 4];
        end
    end

    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz         = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (nib[i] == 4'd0);
            lz[i]      = lz_en_q && (i > 0) && upper_zero;
        end
    end

    always_comb begin
        in_guard    = 32'(cnt_q) < GUARD;
        bin         = 4'd0;
        blank       = 1'b1;
        dig_sel_n   = '1;
        frame_start = 1'b0;
        if (state_q == StScan) begin
            bin         = nib[idx_q];
            frame_start = (cnt_q == '0) && (idx_q == '0);
            if (!in_guard) begin
                dig_sel_n[idx_q] = 1'b0;
                blank            = lz[idx_q];
            end
        end
    end

    assign bus_io.bin         = bin;
    assign bus_io.blank       = blank;
    assign bus_io.dig_sel_n   = dig_sel_n;
    assign bus_io.frame_start = frame_start;
    assign bus_io.pending     = pend_flag_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: vector table of display values plus
// hand sequences for mid-frame load, enable drop and reset mid-scan.
module tb_seven_segment_scanner;
    localparam int ND = 4;
    localparam int PS = 8;
    localparam int G  = 2;

    typedef struct packed {
        logic [3:0] bin;
        logic       blank;
        logic [3:0] dsel;
        logic       fs;
        logic       pend;
    } exp_t;

    typedef struct packed {
        logic [15:0] value;
        logic        lz;
        logic [3:0]  blk;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;
    logic lz_cur = 1'b0;
    exp_t sb[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    seven_segment_scanner_if #(.NUM_DIGITS(ND)) bus_if ();

    seven_segment_scanner #(
        .NUM_DIGITS(ND),
        .PRESCALE  (PS),
        .GUARD     (G)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus_if.slave)
    );

    function automatic logic [3:0] lz_mask(input logic [15:0] shown, input logic lz);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 1; i < ND; i++) m[i] = lz && ((shown >> (4 * i)) == 16'h0);
        return m;
    endfunction

    function automatic exp_t scan_exp(input logic [15:0] shown, input logic [3:0] blk,
                                      input int t, input logic pend);
        exp_t e;
        int idx, cnt;
        logic [3:0] one;
        one    = 4'b0001;
        idx    = (t / PS) % ND;
        cnt    = t % PS;
        e.bin  = shown[4*idx +: 4];
        e.fs   = (idx == 0) && (cnt == 0);
        e.pend = pend;
        if (cnt < G) begin
            e.blank = 1'b1;
            e.dsel  = 4'hF;
        end else begin
            e.blank = blk[idx];
            e.dsel  = ~(one << idx);
        end
        return e;
    endfunction

    task automatic apply(input string nm, input int t);
        exp_t e, got;
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        got = {bus_if.bin, bus_if.blank, bus_if.dig_sel_n, bus_if.frame_start, bus_if.pending};
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s t=%0d: got bin=%h blank=%b dsel=%b fs=%b pend=%b, want bin=%h blank=%b dsel=%b fs=%b pend=%b",
                     nm, t, got.bin, got.blank, got.dsel, got.fs, got.pend,
                     e.bin, e.blank, e.dsel, e.fs, e.pend);
        end
    endtask

    task automatic drive(input logic en, input logic ld, input logic [15:0] val);
        bus_if.enable = en;
        bus_if.load   = ld;
        bus_if.value  = val;
        bus_if.lz_en  = lz_cur;
    endtask

    task automatic step_idle(input string nm, input logic en, input logic ld,
                             input logic [15:0] val, input logic pend);
        drive(en, ld, val);
        sb.push_back({4'h0, 1'b1, 4'hF, 1'b0, pend});
        apply(nm, -1);
    endtask

    task automatic step_scan(input string nm, input int t, input logic [15:0] shown,
                             input logic [3:0] blk, input logic pend, input logic ld,
                             input logic [15:0] val);
        drive(1'b1, ld, val);
        sb.push_back(scan_exp(shown, blk, t, pend));
        apply(nm, t);
    endtask

    task automatic run(input string nm, input int t0, input int t1, input logic [15:0] shown,
                       input logic pend);
        for (int t = t0; t <= t1; t++) step_scan(nm, t, shown, lz_mask(shown, lz_cur), pend,
                                                 1'b0, 16'h0);
    endtask

    task automatic start_frame(input string nm, input logic [15:0] val, input logic [3:0] blk);
        step_idle(nm, 1'b0, 1'b1, val, 1'b1);
        step_scan(nm, 0, val, blk, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        vecs[0] = '{value: 16'h1234, lz: 1'b0, blk: 4'b0000};
        vecs[1] = '{value: 16'h0050, lz: 1'b1, blk: 4'b1100};
        vecs[2] = '{value: 16'h0000, lz: 1'b1, blk: 4'b1110};
        vecs[3] = '{value: 16'h0050, lz: 1'b0, blk: 4'b0000};
        vecs[4] = '{value: 16'h0000, lz: 1'b0, blk: 4'b0000};
        vecs[5] = '{value: 16'hA0F0, lz: 1'b1, blk: 4'b0000};
        vecs[6] = '{value: 16'h0007, lz: 1'b1, blk: 4'b1110};
        vecs[7] = '{value: 16'h0300, lz: 1'b1, blk: 4'b1000};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) step_idle("reset", 1'b0, 1'b0, 16'h0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step_idle("idle", 1'b0, 1'b0, 16'h0, 1'b0);

        // Table: load with scanning off, enable, check one full frame and the next start.
        foreach (vecs[k]) begin
            lz_cur = vecs[k].lz;
            start_frame("vec", vecs[k].value, vecs[k].blk);
            for (int t = 1; t <= 32; t++) begin
                step_scan("vec", t, vecs[k].value, vecs[k].blk, 1'b0, 1'b0, 16'h0);
            end
        end

        // Mid-frame load, then load coinciding with a pending transfer at the wrap.
        lz_cur = 1'b0;
        start_frame("midload", 16'h1234, 4'b0000);
        run("midload", 1, 16, 16'h1234, 1'b0);
        step_scan("midload", 17, 16'h1234, 4'b0000, 1'b1, 1'b1, 16'h9876);
        run("midload", 18, 31, 16'h1234, 1'b1);
        run("midload", 32, 36, 16'h9876, 1'b0);
        step_scan("midload", 37, 16'h9876, 4'b0000, 1'b1, 1'b1, 16'h1111);
        run("midload", 38, 63, 16'h9876, 1'b1);
        step_scan("wrapload", 64, 16'h1111, 4'b0000, 1'b1, 1'b1, 16'h2222);
        run("wrapload", 65, 95, 16'h1111, 1'b1);
        run("wrapload", 96, 99, 16'h2222, 1'b0);

        // Enable drop at idx=1, cnt=4 and immediate re-enable.
        step_idle("endrop", 1'b0, 1'b0, 16'h0, 1'b0);
        start_frame("endrop", 16'h1234, 4'b0000);
        run("endrop", 1, 12, 16'h1234, 1'b0);
        step_idle("endrop", 1'b0, 1'b0, 16'h0, 1'b0);
        run("reenable", 0, 3, 16'h1234, 1'b0);

        // Reset mid-scan with a value pending.
        step_idle("rstmid", 1'b0, 1'b0, 16'h0, 1'b0);
        start_frame("rstmid", 16'h1234, 4'b0000);
        run("rstmid", 1, 9, 16'h1234, 1'b0);
        step_scan("rstmid", 10, 16'h1234, 4'b0000, 1'b1, 1'b1, 16'h5678);
        rst_n = 1'b0;
        step_idle("rstmid", 1'b1, 1'b0, 16'h0, 1'b0);
        rst_n = 1'b1;
        run("postrst", 0, 9, 16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
